// File: rtl/fir_cast_mac.sv
// rtl/fir_cast_mac.sv - sequential single-multiplier FIR with runtime coefficient bank and selectable output cast
module fir_cast_mac #(
  parameter int NTAPS    = 3,
  parameter int SAMP_W   = 15,
  parameter int COEF_W   = 12,
  parameter int ACC_W    = 27,
  parameter int SHIFT    = 11,
  parameter int OUT_W    = 15,
  parameter int SATURATE = 0,
  localparam int AW      = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [SAMP_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat
);

  localparam int PROD_W = COEF_W + SAMP_W;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic signed [SAMP_W-1:0] hist_q [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [AW-1:0]            k_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_cast;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_next;
  logic [ACC_W-OUT_W:0]     top_bits;
  logic                     fits;
  logic [OUT_W-1:0]         cast_data;
  logic                     last_tap;
  logic                     sample_fire;
  logic                     coef_fire;

  assign prod = PROD_W'(coef_q[k_q]) * PROD_W'(hist_q[k_q]);

  generate
    if (ACC_W >= PROD_W) begin : g_prod_ext
      assign prod_cast = ACC_W'(prod);
    end else begin : g_prod_trunc
      assign prod_cast = prod[ACC_W-1:0];
    end
  endgenerate

  assign term     = prod_cast >>> SHIFT;
  assign acc_next = acc_q + term;

  // The value fits OUT_W when every bit above the OUT_W sign bit equals it.
  assign top_bits = acc_next[ACC_W-1:OUT_W-1];
  assign fits     = (&top_bits) || !(|top_bits);

  always_comb begin
    cast_data = acc_next[OUT_W-1:0];
    if (SATURATE != 0 && !fits) begin
      cast_data = acc_next[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  assign last_tap    = (32'(k_q) == NTAPS - 1);
  assign sample_fire = (state_q == IDLE) && in_valid;
  assign coef_fire   = (state_q == IDLE) && coef_we && (32'(coef_addr) < NTAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    coef_ready = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready   = 1'b1;
        coef_ready = 1'b1;
        if (in_valid) begin
          state_d = MAC;
        end
      end
      MAC: begin
        if (last_tap) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-edge coefficient write lands before the MAC that follows reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      acc_q    <= '0;
      k_q      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (coef_fire) begin
        coef_q[coef_addr] <= coef_wdata;
      end
      if (sample_fire) begin
        for (int i = NTAPS - 1; i > 0; i--) begin
          hist_q[i] <= hist_q[i-1];
        end
        hist_q[0] <= in_data;
        acc_q     <= '0;
        k_q       <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_next;
        k_q   <= k_q + AW'(1);
        if (last_tap) begin
          out_data <= cast_data;
          out_sat  <= !fits;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_cast_mac.sv
// tb/tb_fir_cast_mac.sv - directed bench for fir_cast_mac across shift and saturate configurations
module tb_fir_cast_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [11:0] coef_wdata = '0;
  logic        in_valid = 1'b0;
  logic [14:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        cr_a, ir_a, ov_a, os_a;
  logic        cr_b, ir_b, ov_b, os_b;
  logic        cr_c, ir_c, ov_c, os_c;
  logic [14:0] od_a, od_b, od_c;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // a: SHIFT=0 wrap, b: defaults, c: SHIFT=0 saturate; all share stimulus
  fir_cast_mac #(.SHIFT(0), .SATURATE(0)) u_dut_a (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_ready(cr_a), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_sat(os_a)
  );

  fir_cast_mac u_dut_b (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_ready(cr_b), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_sat(os_b)
  );

  fir_cast_mac #(.SHIFT(0), .SATURATE(1)) u_dut_c (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_ready(cr_c), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_sat(os_c)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [11:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = d;
    tick;
    coef_we = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen; lat counts cycles after the handshake cycle.
  task automatic send_and_get(input logic [14:0] s, input logic ordy, output int lat);
    bit ok;
    in_valid = 1'b1;
    in_data = s;
    out_ready = ordy;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ir_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    ok = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ov_a) begin
        lat = n;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("output_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    int pulses;

    do_reset;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_out_valid", {ov_a, ov_b, ov_c}, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_in_ready", {ir_a, ir_b, ir_c}, 7);
    chk("rst_coef_ready", {cr_a, cr_b, cr_c}, 7);
    chk("rst_out_sat", {os_a, os_b, os_c}, 0);
    tick;

    send_and_get(15'd1234, 1'b1, lat);
    chk("zero_coef_a", od_a, 0);
    chk("zero_coef_c", od_c, 0);
    chk("zero_coef_sat", os_a, 0);
    tick;

    do_reset;
    write_coef(2'd0, 12'd1);
    write_coef(2'd1, 12'd2);
    write_coef(2'd2, 12'd3);
    send_and_get(15'd10, 1'b1, lat);
    chk("fir_y0", od_a, 10);
    chk("fir_lat0", lat, 4);
    tick;
    send_and_get(15'd20, 1'b1, lat);
    chk("fir_y1", od_a, 40);
    chk("fir_lat1", lat, 4);
    tick;
    send_and_get(15'd30, 1'b1, lat);
    chk("fir_y2", od_a, 100);
    chk("fir_lat2", lat, 4);
    tick;

    do_reset;
    write_coef(2'd0, 12'h400);
    send_and_get(15'h1000, 1'b1, lat);
    chk("shift_pos", od_b, 2048);
    chk("shift_pos_sat", os_b, 0);
    tick;
    send_and_get(15'h7000, 1'b1, lat);
    chk("shift_neg", od_b, 'h7800);
    chk("shift_neg_sat", os_b, 0);
    tick;

    do_reset;
    write_coef(2'd0, 12'd2047);
    send_and_get(15'h3FFF, 1'b1, lat);
    chk("wrap_pos", od_a, 'h3801);
    chk("wrap_pos_sat", os_a, 1);
    chk("clamp_pos", od_c, 'h3FFF);
    chk("clamp_pos_sat", os_c, 1);
    chk("shift11_pos", od_b, 16375);
    chk("shift11_pos_sat", os_b, 0);
    tick;
    send_and_get(15'h4000, 1'b1, lat);
    chk("clamp_neg", od_c, 'h4000);
    chk("clamp_neg_sat", os_c, 1);
    chk("wrap_neg", od_a, 'h4000);
    chk("wrap_neg_sat", os_a, 1);
    chk("shift11_neg", od_b, 'h4008);
    chk("shift11_neg_sat", os_b, 0);
    tick;

    do_reset;
    write_coef(2'd0, 12'd3);
    send_and_get(15'd5, 1'b0, lat);
    chk("bp_first", od_a, 15);
    tick;
    in_valid = 1'b1;
    in_data = 15'd7;
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_wdata = 12'd100;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (od_a != 15'd15 || !ov_a || ir_a || cr_a) bad++;
      tick;
    end
    chk("bp_hold", bad, 0);
    coef_we = 1'b0;
    out_ready = 1'b1;
    send_and_get(15'd7, 1'b1, lat);
    chk("bp_second", od_a, 21);
    tick;

    do_reset;
    write_coef(2'd0, 12'd1);
    write_coef(2'd1, 12'd2);
    write_coef(2'd2, 12'd3);
    in_valid = 1'b1;
    in_data = 15'd9;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov_a) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    tick;
    send_and_get(15'd50, 1'b1, lat);
    chk("abort_coef_clear", od_a, 0);
    tick;
    write_coef(2'd2, 12'd1);
    write_coef(2'd3, 12'd5);
    send_and_get(15'd0, 1'b1, lat);
    chk("abort_hist_clear", od_a, 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
